// File: rtl/trig_arbiter.sv
// trig_arbiter: round-robin arbiter sharing one fixed-point sin datapath.
// Define TRIG_ARBITER_CLAMP_EN to saturate rsp_sin/rsp_cos to [-1.0, +1.0].
`ifndef FLOAT_BITS
`define FLOAT_BITS 32
`endif
`ifndef FLOAT_DCM_BITS
`define FLOAT_DCM_BITS 14
`endif

module trig_arbiter_sin (
    input  logic signed [`FLOAT_BITS-1:0] a,
    output logic signed [`FLOAT_BITS-1:0] y
);
    localparam int W = `FLOAT_BITS;
    localparam int D = `FLOAT_DCM_BITS;
    localparam logic signed [2*W-1:0] K6   = (2*W)'(10923);
    localparam logic signed [2*W-1:0] K120 = (2*W)'(8738);

    logic signed [2*W-1:0] aw, m2, m3, m5, t3, t5, yw;
    logic                  unused_hi;

    // Three-term Taylor series: a - a^3/6 + a^5/120
    always_comb begin
        aw = a;
        m2 = (aw * aw) >>> D;
        m3 = (m2 * aw) >>> D;
        m5 = (m3 * m2) >>> D;
        t3 = (m3 * K6) >>> 16;
        t5 = (m5 * K120) >>> 20;
        yw = aw - t3 + t5;
        y  = yw[W-1:0];
        unused_hi = ^yw[2*W-1:W];
    end
endmodule

module trig_arbiter #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ),
    parameter logic signed [`FLOAT_BITS-1:0] PI_FX =
        `FLOAT_BITS'($rtoi(3.141592653589793 * (1 << `FLOAT_DCM_BITS) + 0.5)),
    parameter logic signed [`FLOAT_BITS-1:0] HALF_PI_FX =
        `FLOAT_BITS'($rtoi(1.5707963267948966 * (1 << `FLOAT_DCM_BITS) + 0.5)),
    parameter logic signed [`FLOAT_BITS-1:0] TWO_PI_FX =
        `FLOAT_BITS'($rtoi(6.283185307179586 * (1 << `FLOAT_DCM_BITS) + 0.5))
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req_valid,
    output logic [N_REQ-1:0]                    req_ready,
    input  logic [N_REQ-1:0][`FLOAT_BITS-1:0]   req_angle,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [ID_W-1:0]                     rsp_id,
    output logic signed [`FLOAT_BITS-1:0]       rsp_sin,
    output logic signed [`FLOAT_BITS-1:0]       rsp_cos,
    output logic                                busy
);
    localparam int W = `FLOAT_BITS;
    localparam logic signed [W-1:0] ONE_FX = W'(1 << `FLOAT_DCM_BITS);

    typedef enum logic [2:0] {
        IDLE, REDUCE, FOLD, EVAL_SIN, EVAL_COS, RESP
    } state_t;

    state_t              st, nxt;
    logic [ID_W-1:0]     rr_ptr, id, gnt_id, cand;
    logic                gnt_any, neg_cos;
    logic signed [W-1:0] x, s, absx, dp_in, dp_out;

    function automatic logic signed [W-1:0] sat(input logic signed [W-1:0] v);
`ifdef TRIG_ARBITER_CLAMP_EN
        if (v > ONE_FX) return ONE_FX;
        if (v < -ONE_FX) return -ONE_FX;
        return v;
`else
        return v;
`endif
    endfunction

    trig_arbiter_sin u_sin (
        .a (dp_in),
        .y (dp_out)
    );

    // Round-robin search starting just after the last winner
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = st;
        unique case (st)
            IDLE:     if (gnt_any) nxt = REDUCE;
            REDUCE:   if (!(x >= PI_FX) && !(x < -PI_FX)) nxt = FOLD;
            FOLD:     nxt = EVAL_SIN;
            EVAL_SIN: nxt = EVAL_COS;
            EVAL_COS: nxt = RESP;
            RESP:     if (rsp_ready) nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Outputs and shared-datapath input mux
    always_comb begin
        req_ready = '0;
        dp_in     = '0;
        absx      = x[W-1] ? -x : x;
        busy      = (st != IDLE);
        rsp_valid = (st == RESP);
        if (st == IDLE && gnt_any && !rst) req_ready[gnt_id] = 1'b1;
        if (st == EVAL_SIN) dp_in = x;
        if (st == EVAL_COS) dp_in = HALF_PI_FX - absx;
    end

    // Angle capture, reduction, fold and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            s       <= '0;
            id      <= '0;
            neg_cos <= 1'b0;
            rr_ptr  <= ID_W'(N_REQ - 1);
            rsp_id  <= '0;
            rsp_sin <= '0;
            rsp_cos <= '0;
        end else begin
            unique case (st)
                IDLE: if (gnt_any) begin
                    x      <= req_angle[gnt_id];
                    id     <= gnt_id;
                    rr_ptr <= gnt_id;
                end
                REDUCE: begin
                    if (x >= PI_FX)       x <= x - TWO_PI_FX;
                    else if (x < -PI_FX)  x <= x + TWO_PI_FX;
                end
                FOLD: begin
                    if (x > HALF_PI_FX) begin
                        x       <= PI_FX - x;
                        neg_cos <= 1'b1;
                    end else if (x < -HALF_PI_FX) begin
                        x       <= -PI_FX - x;
                        neg_cos <= 1'b1;
                    end else begin
                        neg_cos <= 1'b0;
                    end
                end
                EVAL_SIN: s <= dp_out;
                EVAL_COS: begin
                    rsp_sin <= sat(s);
                    rsp_cos <= sat(neg_cos ? -dp_out : dp_out);
                    rsp_id  <= id;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trig_arbiter.sv
// tb_trig_arbiter: directed stimulus, reference model and per-cycle compare.
// Fixed point assumed: 32 bits, 14 fractional bits.
module tb_trig_arbiter;
    localparam longint ONE  = 16384;
    localparam longint PI   = 51472;
    localparam longint HALF = 25736;
    localparam longint TWO  = 102944;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        req_valid = '0;
    logic [3:0]        req_ready;
    logic [3:0][31:0]  req_angle = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic signed [31:0] rsp_sin, rsp_cos;
    logic              busy;

    int n_chk = 0;
    int n_fail = 0;
    int n_rsp = 0;
    bit chk_en = 0;
    int ids[$];

    trig_arbiter #(.N_REQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_angle(req_angle),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sin(rsp_sin), .rsp_cos(rsp_cos),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act,
                       input longint exp, input longint tol);
        n_chk++;
        if (act - exp > tol || exp - act > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)",
                     nm, act, exp, tol);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real taylor(input longint q);
        real v;
        v = real'(q) / real'(ONE);
        return (v - v*v*v/6.0 + v*v*v*v*v/120.0) * real'(ONE);
    endfunction

    function automatic longint clampv(input longint v);
`ifdef TRIG_ARBITER_CLAMP_EN
        if (v > ONE) return ONE;
        if (v < -ONE) return -ONE;
`endif
        return v;
    endfunction

    function automatic int pick(input int rr, input logic [3:0] v);
        for (int k = 1; k <= 4; k++)
            if (v[(rr + k) % 4]) return (rr + k) % 4;
        return -1;
    endfunction

    bit     m_idle = 1, m_resp = 0;
    int     m_cnt = 0, m_rr = 3, m_id = 0;
    longint m_sin = 0, m_cos = 0;

    always @(posedge clk or posedge rst) begin
        int g, k;
        longint v, c;
        bit neg;
        if (rst) begin
            m_idle = 1; m_resp = 0; m_cnt = 0; m_rr = 3;
        end else if (m_idle) begin
            g = pick(m_rr, req_valid);
            if (g >= 0) begin
                v = longint'(signed'(req_angle[g]));
                k = 0;
                forever begin
                    if (v >= PI) v -= TWO;
                    else if (v < -PI) v += TWO;
                    else break;
                    k++;
                end
                neg = 0;
                if (v > HALF) begin v = PI - v; neg = 1; end
                else if (v < -HALF) begin v = -PI - v; neg = 1; end
                c = longint'(taylor(HALF - (v < 0 ? -v : v)));
                m_sin = clampv(longint'(taylor(v)));
                m_cos = clampv(neg ? -c : c);
                m_id = g; m_rr = g; m_idle = 0; m_cnt = 4 + k;
            end
        end else if (m_resp) begin
            if (rsp_ready) begin m_resp = 0; m_idle = 1; end
        end else begin
            m_cnt--;
            if (m_cnt == 0) m_resp = 1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        int g;
        logic [3:0] er;
        if (chk_en) begin
            er = '0;
            g = pick(m_rr, req_valid);
            if (m_idle && !rst && g >= 0) er[g] = 1'b1;
            chk("req_ready", req_ready, er, 0);
            chk("rsp_valid", rsp_valid, m_resp, 0);
            chk("busy", busy, !m_idle, 0);
            if (m_resp) begin
                chk("rsp_id", rsp_id, m_id, 0);
                chk("rsp_sin", rsp_sin, m_sin, 4);
                chk("rsp_cos", rsp_cos, m_cos, 4);
            end
        end
    end

    always @(negedge clk)
        if (rsp_valid && rsp_ready && !rst) begin
            ids.push_back(int'(rsp_id));
            n_rsp++;
        end

    // One transaction; returns latency and response fields
    task automatic run_one(input int r, input longint ang, output int lat,
                           output int rid, output longint s, output longint c);
        int n = 0;
        req_angle[r] = 32'(ang);
        req_valid = 4'(1 << r);
        rsp_ready = 1'b1;
        do begin @(negedge clk); n++; end while (!req_ready[r] && n < 50);
        if (!req_ready[r]) chk("grant_timeout", 0, 1, 0);
        @(posedge clk); #1;
        req_valid = '0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!rsp_valid && lat < 100);
        if (!rsp_valid) chk("rsp_timeout", 0, 1, 0);
        rid = int'(rsp_id);
        s = longint'(rsp_sin);
        c = longint'(rsp_cos);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rid, n;
        longint s, c;
        int exp_ids[8] = '{0, 1, 2, 3, 0, 2, 0, 2};

        req_valid = 4'b0100;
        @(posedge clk);
        chk_en = 1;
        @(posedge clk); #1;
        chk("reset_rsp_valid", rsp_valid, 0, 0);
        chk("reset_busy", busy, 0, 0);
        chk("reset_req_ready", req_ready, 0, 0);
        chk("reset_rsp_id", rsp_id, 0, 0);
        chk("reset_rsp_sin", rsp_sin, 0, 0);
        chk("reset_rsp_cos", rsp_cos, 0, 0);
        rst = 1'b0;
        req_valid = '0;

        // angle 0
        run_one(2, 0, lat, rid, s, c);
        chk("t1_latency", lat, 4, 0);
        chk("t1_id", rid, 2, 0);
        chk("t1_sin", s, 0, 0);
`ifdef TRIG_ARBITER_CLAMP_EN
        chk("t1_cos", c, 16384, 0);
`else
        chk("t1_cos", c, 16458, 3);
`endif

        // angle exactly pi
        run_one(0, PI, lat, rid, s, c);
        chk("t2_latency", lat, 5, 0);
        chk("t2_id", rid, 0, 0);
        chk("t2_sin", s, 0, 0);
`ifdef TRIG_ARBITER_CLAMP_EN
        chk("t2_cos", c, -16384, 0);
`else
        chk("t2_cos", c, -16458, 3);
`endif

        // angle 7.0 rad
        run_one(1, 7 * ONE, lat, rid, s, c);
        chk("t3_latency", lat, 5, 0);
        chk("t3_id", rid, 1, 0);
        chk("t3_sin", s, 10764, 6);
        chk("t3_cos", c, 12353, 6);

        // round-robin fairness
        do_reset();
        ids.delete();
        req_angle[0] = 32'(1000);
        req_angle[1] = 32'(-2000);
        req_angle[2] = 32'(30000);
        req_angle[3] = 32'(-60000);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        n = 0;
        while (ids.size() < 4 && n < 200) begin @(posedge clk); #1; n++; end
        req_valid = 4'b0101;
        n = 0;
        while (ids.size() < 8 && n < 200) begin @(posedge clk); #1; n++; end
        req_valid = '0;
        if (ids.size() < 8) chk("t4_rsp_count", ids.size(), 8, 0);
        for (int i = 0; i < 8 && i < ids.size(); i++)
            chk($sformatf("t4_order_%0d", i), ids[i], exp_ids[i], 0);
        repeat (2) @(posedge clk); #1;

        // back-pressure in RESP
        rsp_ready = 1'b0;
        req_angle[3] = 32'(20000);
        req_valid = 4'b1000;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[3] && n < 50);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", rsp_valid, 1, 0);
            chk("t5_hold_id", rsp_id, 3, 0);
            chk("t5_hold_ready", req_ready, 0, 0);
            chk("t5_hold_busy", busy, 1, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("t5_idle_busy", busy, 0, 0);
        chk("t5_idle_valid", rsp_valid, 0, 0);
        req_valid = '0;
        repeat (2) @(posedge clk); #1;

        // reset during reduction
        req_angle[3] = 32'(40 * ONE);
        req_valid = 4'b1000;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[3] && n < 50);
        @(posedge clk); #1;
        req_valid = '0;
        n = n_rsp;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0, 0);
        chk("t6_rst_valid", rsp_valid, 0, 0);
        chk("t6_rst_ready", req_ready, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req_valid = 4'b1001;
        chk("t6_no_rsp", n_rsp, n, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 0 && n < 50);
        chk("t6_first_grant", req_ready, 4'b0001, 0);
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("t6_rsp_id", rsp_id, 0, 0);
        repeat (3) @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/trig_arbiter.md
Name: trig_arbiter

Overview:
- Shares one combinational `sin` datapath instance among N_REQ requesters, for example the tangram piece-rotation units.
- Each request carries one angle. The block returns the sin and cos of that angle.
- Per request it sequences: round-robin grant, range reduction to [-π, π), quadrant fold to [-π/2, π/2], then two evaluations on the shared datapath (sin, then cos).
- The response is held under a valid/ready handshake.

Parameters:
- N_REQ, 4, number of requesters (2..16). Localparam ID_W = $clog2(N_REQ).
- PI_FX, round(π·2^`FLOAT_DCM_BITS), fixed-point π.
- HALF_PI_FX, round(π/2·2^`FLOAT_DCM_BITS), fixed-point π/2.
- TWO_PI_FX, round(2π·2^`FLOAT_DCM_BITS), fixed-point 2π.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_angle  in  N_REQ×`FLOAT_BITS  signed fixed-point angle per requester, any value.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_sin  out  `FLOAT_BITS  sin(angle), signed fixed point.
- rsp_cos  out  `FLOAT_BITS  cos(angle), signed fixed point.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All arithmetic is signed, `FLOAT_BITS wide, with `FLOAT_DCM_BITS fractional bits. The shared `sin` instance is the only multiplier resource.
- Reset (asynchronous, immediate):
  - state = IDLE; rr_ptr = N_REQ-1, so requester 0 wins first.
  - rsp_valid = 0; rsp_id, rsp_sin, rsp_cos = 0.
  - req_ready = 0 while rst is high.
  - Any in-flight request is dropped with no response.
- FSM states: IDLE, REDUCE, FOLD, EVAL_SIN, EVAL_COS, RESP.
- IDLE:
  - Grant goes to the first i with req_valid[i], searching from rr_ptr+1 upward and wrapping modulo N_REQ.
  - req_ready[i] = 1 combinationally for the winner only; req_ready is 0 in every other state.
  - On the handshake: capture req_angle[i] into x, capture id = i, set rr_ptr = i, go to REDUCE.
  - With no req_valid bits set: stay in IDLE.
- REDUCE: one correction per cycle.
  - If x ≥ PI_FX: x -= TWO_PI_FX.
  - Else if x < -PI_FX: x += TWO_PI_FX.
  - Else go to FOLD.
- FOLD (one cycle):
  - If x > HALF_PI_FX: x' = PI_FX - x, neg_cos = 1.
  - Else if x < -HALF_PI_FX: x' = -PI_FX - x, neg_cos = 1.
  - Else x' = x, neg_cos = 0.
  - Then go to EVAL_SIN.
- EVAL_SIN: datapath input = x'; register s = sin(x'); go to EVAL_COS.
- EVAL_COS:
  - Datapath input = HALF_PI_FX - |x'|; result c.
  - Register rsp_cos = neg_cos ? -c : c and rsp_sin = s.
  - Set rsp_valid = 1, drive rsp_id = id, go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_sin and rsp_cos stay stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid drops on the same edge, go to IDLE.
  - The next grant happens in IDLE, so back-to-back throughput is at most one request per 6+k cycles.
- Latency: from the accept edge to the first cycle rsp_valid is high = 4 + k clocks, where k is the number of reduction corrections.
  - This counts REDUCE's final check cycle, FOLD, EVAL_SIN and EVAL_COS.
- Boundaries:
  - Angle exactly PI_FX reduces to -PI_FX.
  - Angle exactly ±HALF_PI_FX is not folded.
  - A req_valid drop while the requester is not granted has no effect; the request is not queued.
  - Requesters raising valid while the block is busy wait; fairness is by rr_ptr only.
  - Simultaneous rsp handshake and new req_valid: the grant happens next cycle, in IDLE.
- Datapath input mux defaults to 0 outside the EVAL states.

Optional Feature:
- Macro: TRIG_ARBITER_CLAMP_EN.
- When defined: rsp_sin and rsp_cos are saturated to [-ONE_FX, +ONE_FX], where ONE_FX = 1<<`FLOAT_DCM_BITS. The Taylor series overshoots at ±π/2 (≈1.0045).
- When undefined: the raw datapath results are returned unchanged.
- Latency is identical either way.

Test Plan:
- Reset, then req_valid[2]=1, angle 0, rsp_ready=1.
  - Expect req_ready[2] for one cycle, rsp_valid 4 clocks after accept.
  - Expect rsp_id=2, rsp_sin=0, rsp_cos=sin-model(HALF_PI_FX): ≈1.0045, or exactly ONE_FX with the clamp.
- Angle PI_FX: expect one REDUCE correction to -PI_FX, fold to x'=0, rsp_sin=0, rsp_cos=-(value from previous test), latency 5.
- Angle 7.0 rad: expect k=1 (7.0-2π≈0.7168), latency 5, rsp_sin≈0.6570, rsp_cos≈0.7539, within ±4 LSB of the bit-exact model.
- After reset, all four req_valid held high with distinct angles:
  - Expect grants in order 0,1,2,3, rsp_id matching in order.
  - Then drop valids 1 and 3: subsequent order is 0,2,0,2.
- During RESP, hold rsp_ready=0 for 10 cycles:
  - rsp_valid and all rsp_* fields stay stable; req_ready stays 0; busy=1.
  - Release rsp_ready: IDLE next cycle.
- Angle 40.0 rad (k=6); assert rst during the 3rd REDUCE cycle:
  - busy and rsp_valid go 0 immediately; no response is emitted.
  - After release, requester 0 wins the first grant.
